// File: rtl/spi_master_byte.sv
// spi_master_byte: byte-oriented SPI master, mode 0 (SCK idle low, MOSI
// driven on falling edges, MISO sampled on rising edges).
//
// A byte offered on the valid/ready input is shifted out on MOSI while the
// MISO byte is assembled and returned as a one-cycle oRX_VALID pulse.
// Chip-select may be held low across bytes (iHOLD_CS) and dropped later with
// iRELEASE.
//
// Build option: define SPI_MASTER_LSB_FIRST_EN to shift LSB first in both
// directions (the first received bit lands in bit 0). Without it, transfers
// are MSB first. Port list and timing are identical either way.
module spi_master_byte #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              iCLK,
  input  logic              iRESETn,
  input  logic [DATA_W-1:0] iTX_DATA,
  input  logic              iTX_VALID,
  input  logic              iHOLD_CS,
  output logic              oTX_READY,
  input  logic              iRELEASE,
  output logic [DATA_W-1:0] oRX_DATA,
  output logic              oRX_VALID,
  output logic              oBUSY,
  output logic              oSPI_SCK,
  output logic              oSPI_MOSI,
  input  logic              iSPI_MISO,
  output logic              oSPI_CSn
);

  // Parameter sanity checks, evaluated at elaboration.
  if (CLK_DIV < 1) begin : gDivCheck
    $error("spi_master_byte: CLK_DIV must be >= 1 (got %0d)", CLK_DIV);
  end
  if (DATA_W < 1) begin : gWidthCheck
    $error("spi_master_byte: DATA_W must be >= 1 (got %0d)", DATA_W);
  end

  // Divider width is kept at least one bit so CLK_DIV=1 still elaborates;
  // in that case the counter sits at zero and every cycle is a tick.
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // Half-period counter spans 0 .. 2*DATA_W-1.
  localparam int HW = $clog2(2 * DATA_W);

  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_SHIFT,
    ST_CSHOLD,
    ST_GAP
  } stateT;

  stateT             state;
  logic [CW-1:0]     divCnt;
  logic [HW-1:0]     halfCnt;
  logic [DATA_W-1:0] txShift;
  logic [DATA_W-1:0] rxShift;
  logic              holdFlag;

  logic              halfTick;
  logic [DATA_W-1:0] txNext;

  // Bit that goes onto MOSI first from a freshly loaded shift register.
  function automatic logic firstBit(input logic [DATA_W-1:0] v);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return v[0];
`else
    return v[DATA_W-1];
`endif
  endfunction

  // Drops the bit just transmitted so the next one sits at the output end.
  function automatic logic [DATA_W-1:0] txAdvance(input logic [DATA_W-1:0] v);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return v >> 1;
`else
    return v << 1;
`endif
  endfunction

  // Inserts a sampled MISO bit. LSB-first fills from the top so that after
  // DATA_W samples the first bit received has walked down into bit 0.
  function automatic logic [DATA_W-1:0] rxInsert(input logic [DATA_W-1:0] v,
                                                input logic              b);
    logic [DATA_W-1:0] r;
`ifdef SPI_MASTER_LSB_FIRST_EN
    r = v >> 1;
    r[DATA_W-1] = b;
`else
    r = v << 1;
    r[0] = b;
`endif
    return r;
  endfunction

  // Divider terminal count marks the end of an SCK half-period.
  assign halfTick = (divCnt == DIV_LAST);
  assign txNext   = txAdvance(txShift);

  // Busy whenever a frame is running or a held chip-select is still asserted.
  assign oBUSY = (state != ST_IDLE) | ~oSPI_CSn;

  // Transfer FSM: drives all SPI pins, the divider and the shift registers.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state     <= ST_IDLE;
      divCnt    <= '0;
      halfCnt   <= '0;
      txShift   <= '0;
      rxShift   <= '0;
      holdFlag  <= 1'b0;
      oTX_READY <= 1'b1;
      oRX_DATA  <= '0;
      oRX_VALID <= 1'b0;
      oSPI_SCK  <= 1'b0;
      oSPI_MOSI <= 1'b0;
      oSPI_CSn  <= 1'b1;
    end else begin
      oRX_VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          divCnt  <= '0;
          halfCnt <= '0;
          // An accept takes priority over a simultaneous release request.
          if (iTX_VALID && oTX_READY) begin
            txShift   <= iTX_DATA;
            holdFlag  <= iHOLD_CS;
            oTX_READY <= 1'b0;
            state     <= ST_LOAD;
          end else if (iRELEASE && !oSPI_CSn) begin
            oTX_READY <= 1'b0;
            state     <= ST_CSHOLD;
          end
        end

        ST_LOAD: begin
          // Select the slave and present the first data bit. A chip-select
          // that is already low from a held frame needs no setup time.
          oSPI_CSn  <= 1'b0;
          oSPI_SCK  <= 1'b0;
          oSPI_MOSI <= firstBit(txShift);
          divCnt    <= '0;
          halfCnt   <= '0;
          state     <= oSPI_CSn ? ST_SETUP : ST_SHIFT;
        end

        ST_SETUP: begin
          if (halfTick) begin
            divCnt <= '0;
            state  <= ST_SHIFT;
          end else begin
            divCnt <= divCnt + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (halfTick) begin
            divCnt <= '0;
            if (!halfCnt[0]) begin
              // Rising edge: the slave has had a full half-period to drive MISO.
              oSPI_SCK <= 1'b1;
              rxShift  <= rxInsert(rxShift, iSPI_MISO);
              halfCnt  <= halfCnt + 1'b1;
            end else if (halfCnt == HALF_LAST) begin
              // Final falling edge: hand back the received word.
              oSPI_SCK  <= 1'b0;
              oSPI_MOSI <= 1'b0;
              oRX_DATA  <= rxShift;
              oRX_VALID <= 1'b1;
              halfCnt   <= '0;
              if (holdFlag) begin
                oTX_READY <= 1'b1;
                state     <= ST_IDLE;
              end else begin
                state <= ST_CSHOLD;
              end
            end else begin
              // Falling edge: move MOSI on to the next bit.
              oSPI_SCK  <= 1'b0;
              oSPI_MOSI <= firstBit(txNext);
              txShift   <= txNext;
              halfCnt   <= halfCnt + 1'b1;
            end
          end else begin
            divCnt <= divCnt + 1'b1;
          end
        end

        ST_CSHOLD: begin
          // SCK stays low for one half-period before deselecting.
          if (halfTick) begin
            divCnt   <= '0;
            oSPI_CSn <= 1'b1;
            state    <= ST_GAP;
          end else begin
            divCnt <= divCnt + 1'b1;
          end
        end

        ST_GAP: begin
          // Minimum deselect time before the next frame may start.
          if (halfTick) begin
            divCnt    <= '0;
            oTX_READY <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            divCnt <= divCnt + 1'b1;
          end
        end

        default: begin
          oTX_READY <= 1'b1;
          oSPI_SCK  <= 1'b0;
          oSPI_CSn  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Testbench for spi_master_byte: a mode-0 slave model answers each frame,
// a scoreboard holds the expected MISO word and MOSI word per accepted byte,
// and timing is measured in clock edges from the accept edge.
module tb_spi_master_byte;

  localparam int H  = 2;
  localparam int DW = 8;
`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam bit LSBF = 1'b1;
`else
  localparam bit LSBF = 1'b0;
`endif

  logic          iCLK = 1'b0;
  logic          iRESETn = 1'b0;
  logic [DW-1:0] txData = '0;
  logic          txValid = 1'b0;
  logic          txHold = 1'b0;
  logic          txReady;
  logic          release_ = 1'b0;
  logic [DW-1:0] rxData;
  logic          rxValid;
  logic          busy;
  logic          sck;
  logic          mosi;
  logic          miso;
  logic          csn;

  logic [DW-1:0] tx1Data = '0;
  logic          tx1Valid = 1'b0;
  logic          ready1;
  logic [DW-1:0] rx1Data;
  logic          rx1Valid;
  logic          busy1;
  logic          sck1;
  logic          mosi1;
  logic          miso1 = 1'b0;
  logic          csn1;

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  spi_master_byte #(.CLK_DIV(H), .DATA_W(DW)) u_dut (
    .iCLK(iCLK), .iRESETn(iRESETn),
    .iTX_DATA(txData), .iTX_VALID(txValid), .iHOLD_CS(txHold),
    .oTX_READY(txReady), .iRELEASE(release_),
    .oRX_DATA(rxData), .oRX_VALID(rxValid), .oBUSY(busy),
    .oSPI_SCK(sck), .oSPI_MOSI(mosi), .iSPI_MISO(miso), .oSPI_CSn(csn)
  );

  spi_master_byte #(.CLK_DIV(1), .DATA_W(DW)) u_dut1 (
    .iCLK(iCLK), .iRESETn(iRESETn),
    .iTX_DATA(tx1Data), .iTX_VALID(tx1Valid), .iHOLD_CS(1'b0),
    .oTX_READY(ready1), .iRELEASE(1'b0),
    .oRX_DATA(rx1Data), .oRX_VALID(rx1Valid), .oBUSY(busy1),
    .oSPI_SCK(sck1), .oSPI_MOSI(mosi1), .iSPI_MISO(miso1), .oSPI_CSn(csn1)
  );

  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected MISO word and expected MOSI word per accepted byte.
  logic [DW-1:0] expRx[$];
  logic [DW-1:0] expTx[$];

  // Mode-0 slave: current bit visible before each rise, advances on falls.
  logic [DW-1:0] slaveCur = '0;
  logic [DW-1:0] slaveNext = '0;
  logic          slaveLoadTgl = 1'b0;
  logic          slaveSeenTgl = 1'b0;
  int            slaveIdx = 0;

  function automatic logic bitAt(input logic [DW-1:0] v, input int i);
    logic b;
    b = 1'b0;
    for (int k = 0; k < DW; k++)
      if (k == i) b = LSBF ? v[k] : v[DW-1-k];
    return b;
  endfunction

  assign miso = bitAt(slaveCur, slaveIdx);

  always @(negedge sck or slaveLoadTgl) begin
    if (slaveLoadTgl != slaveSeenTgl) begin
      slaveSeenTgl = slaveLoadTgl;
      slaveCur     = slaveNext;
      slaveIdx     = 0;
    end else begin
      slaveIdx = slaveIdx + 1;
    end
  end

  // MOSI capture at each SCK rise, assembled in the configured bit order.
  int            bitCnt;
  logic [DW-1:0] mosiByte;
  always @(posedge sck or negedge iRESETn) begin
    if (!iRESETn) begin
      bitCnt   <= 0;
      mosiByte <= '0;
    end else begin
      bitCnt   <= bitCnt + 1;
      mosiByte <= LSBF ? {mosi, mosiByte[DW-1:1]} : {mosiByte[DW-2:0], mosi};
    end
  end

  // Output monitor, sampled on the falling clock edge.
  int   rxCount = 0;
  int   bitBase = 0;
  int   sckViol = 0;
  int   csnRises = 0;
  int   runLen = 0;
  int   minGap = 1000;
  logic prevCsn = 1'b1;
  always @(negedge iCLK) begin
    if (!iRESETn) begin
      expRx.delete();
      expTx.delete();
      bitBase = 0;
      prevCsn = 1'b1;
    end else begin
      if (rxValid) begin
        rxCount++;
        checkEq("rxQueued", expRx.size() > 0, 1);
        if (expRx.size() > 0) begin
          checkEq("rxData", rxData, expRx.pop_front());
          checkEq("mosiByte", mosiByte, expTx.pop_front());
          checkEq("sckRises", bitCnt - bitBase, DW);
          bitBase = bitCnt;
        end
      end
      if (csn && sck) sckViol++;
      if (csn) runLen++;
      if (!csn && prevCsn) begin
        if (csnRises > 0 && runLen < minGap) minGap = runLen;
        runLen = 0;
      end
      if (csn && !prevCsn) csnRises++;
      prevCsn = csn;
    end
  end

  function automatic logic evCond(input int sel);
    case (sel)
      0: return rxValid;
      1: return csn;
      2: return txReady;
      3: return sck;
      4: return (bitCnt - bitBase) == 3;
      5: return sck1;
      6: return rx1Valid;
      7: return (expRx.size() == 0) && txReady && csn;
      default: return 1'b0;
    endcase
  endfunction

  // Waits on falling edges for a condition; atCyc = -1 when the bound expires.
  task automatic waitEvent(input int sel, input int limit, output int atCyc);
    atCyc = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge iCLK);
      if (evCond(sel)) begin
        atCyc = cyc;
        break;
      end
    end
  endtask

  // Offers one byte; returns the clock edge on which it is accepted.
  task automatic sendByte(input logic [DW-1:0] d, input logic hold,
                          input logic [DW-1:0] ret, input bit keepValid,
                          output int acc);
    int n;
    @(negedge iCLK);
    txValid = 1'b1;
    n = 0;
    while (!txReady && n < 400) begin
      @(negedge iCLK);
      n++;
    end
    checkEq("acceptReady", txReady, 1);
    txData = d;
    txHold = hold;
    expRx.push_back(ret);
    expTx.push_back(d);
    slaveNext = ret;
    slaveLoadTgl = ~slaveLoadTgl;
    acc = cyc + 1;
    @(negedge iCLK);
    if (!keepValid) txValid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, t, t2, r0, rel, hiSeen;

    // Reset state.
    #12;
    checkEq("rstCsn", csn, 1);
    checkEq("rstSck", sck, 0);
    checkEq("rstMosi", mosi, 0);
    checkEq("rstRxData", rxData, 0);
    checkEq("rstRxValid", rxValid, 0);
    checkEq("rstReady", txReady, 1);
    checkEq("rstBusy", busy, 0);
    @(negedge iCLK);
    #1 iRESETn = 1'b1;

    // Single fresh frame with full timing.
    sendByte(8'hA5, 1'b0, 8'h3C, 1'b0, acc);
    waitEvent(0, 100, t);
    checkEq("t1RxLat", t - acc, 1 + 2*DW*H + H);
    checkEq("t1Busy", busy, 1);
    waitEvent(1, 100, t);
    checkEq("t1CsHighLat", t - acc, 1 + (2*DW+2)*H);
    waitEvent(2, 100, t);
    checkEq("t1ReadyLat", t - acc, 1 + (2*DW+3)*H);
    checkEq("t1BusyIdle", busy, 0);

    // Held chip-select across two bytes; second byte skips setup.
    r0 = csnRises;
    sendByte(8'h12, 1'b1, 8'hA7, 1'b0, acc);
    waitEvent(0, 100, t);
    waitEvent(2, 100, t);
    checkEq("t2CsHeld", csn, 0);
    sendByte(8'h34, 1'b0, 8'h5E, 1'b0, acc2);
    waitEvent(3, 50, t);
    checkEq("t2NoSetup", t - acc2, 1 + H);
    waitEvent(0, 100, t);
    checkEq("t2RxLat2", t - acc2, 1 + 2*DW*H);
    waitEvent(2, 100, t);
    checkEq("t2OneDeselect", csnRises - r0, 1);

    // Held byte, long idle, then explicit release.
    sendByte(8'h5A, 1'b1, 8'hC3, 1'b0, acc);
    waitEvent(0, 100, t);
    hiSeen = 0;
    repeat (20) begin
      @(negedge iCLK);
      if (csn) hiSeen++;
    end
    checkEq("t3CsHeldIdle", hiSeen, 0);
    checkEq("t3BusyHeld", busy, 1);
    checkEq("t3ReadyHeld", txReady, 1);
    release_ = 1'b1;
    rel = cyc + 1;
    @(negedge iCLK);
    release_ = 1'b0;
    waitEvent(1, 50, t);
    checkEq("t3RelCsLat", t - rel, H);
    waitEvent(2, 50, t);
    checkEq("t3RelReadyLat", t - rel, 2*H);
    // Release with CSn already high does nothing.
    release_ = 1'b1;
    @(negedge iCLK);
    release_ = 1'b0;
    checkEq("t3RelIgnReady", txReady, 1);
    checkEq("t3RelIgnBusy", busy, 0);

    // Valid held high continuously across three frames.
    sendByte(8'h81, 1'b0, 8'h18, 1'b1, acc);
    sendByte(8'h42, 1'b0, 8'h24, 1'b1, acc);
    sendByte(8'hF0, 1'b0, 8'h0F, 1'b0, acc);
    waitEvent(7, 400, t);
    checkEq("t4Drained", expRx.size(), 0);
    checkEq("t4SckIdleLow", sckViol, 0);
    checkEq("t4MinGap", minGap >= H, 1);

    // Reset in the middle of a shift.
    sendByte(8'hC3, 1'b0, 8'h99, 1'b0, acc);
    waitEvent(4, 100, t);
    checkEq("t5ThreeRises", t > 0, 1);
    r0 = rxCount;
    #1 iRESETn = 1'b0;
    #1;
    checkEq("t5RstCsn", csn, 1);
    checkEq("t5RstSck", sck, 0);
    checkEq("t5RstRxValid", rxValid, 0);
    repeat (3) @(negedge iCLK);
    checkEq("t5NoRxPulse", rxCount, r0);
    #1 iRESETn = 1'b1;
    @(negedge iCLK);
    checkEq("t5ReadyAfter", txReady, 1);
    sendByte(8'h7E, 1'b0, 8'h81, 1'b0, acc);
    waitEvent(0, 100, t);
    checkEq("t5RxLat", t - acc, 1 + 2*DW*H + H);
    waitEvent(2, 100, t);

    // CLK_DIV=1 instance: first bit on MISO only.
    @(negedge iCLK);
    checkEq("t6Ready", ready1, 1);
    tx1Data = 8'h01;
    tx1Valid = 1'b1;
    miso1 = 1'b1;
    acc = cyc + 1;
    @(negedge iCLK);
    tx1Valid = 1'b0;
    waitEvent(5, 50, t);
    checkEq("t6FirstMosi", mosi1, LSBF ? 1 : 0);
    @(negedge iCLK);
    miso1 = 1'b0;
    waitEvent(5, 10, t2);
    checkEq("t6SckPeriod", t2 - t, 2);
    waitEvent(6, 50, t);
    checkEq("t6RxLat", t - acc, 1 + 2*DW + 1);
    checkEq("t6RxData", rx1Data, LSBF ? 32'h01 : 32'h80);
    repeat (5) @(negedge iCLK);
    checkEq("t6Idle", ready1, 1);

    checkEq("rxCount", rxCount, 8);
    checkEq("sbEmpty", expRx.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
